// File: rtl/corr_acq_sequencer.sv
// Correlator acquisition sequencer: resets and configures the correlator,
// waits for completion or timeout, then streams a status frame over UART.
//
// Ports:
//   sys_clk, sys_rst         rising-edge clock, synchronous active-high reset
//   start                    single-cycle acquisition request (IDLE only)
//   cr_value                 control word written to the correlator in CFG
//   sr_in                    correlator status: bit0 done, bit1 failure
//   sum_*                    six 64-bit correlator accumulators
//   tx_ready                 UART accepts the presented byte
//   corr_reset               correlator reset, held RST_CYCLES cycles
//   we, cr                   control-register write strobe and data
//   tx_byte, tx_valid        UART byte stream (A5, status, 48 data bytes)
//   busy                     high whenever the sequencer is not idle
//   timeout_err              sticky RUN-timeout flag, cleared by next start
module corr_acq_sequencer #(
   parameter int unsigned RST_CYCLES = 16,
   parameter logic [31:0] TIMEOUT    = 32'd10000000
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        start,
   input  logic [31:0] cr_value,
   input  logic [31:0] sr_in,
   input  logic [63:0] sum_x_2,
   input  logic [63:0] sum_y_2,
   input  logic [63:0] sum_xy,
   input  logic [63:0] sum_xy90,
   input  logic [63:0] sum_y90_2,
   input  logic [63:0] sum_y_y90,
   input  logic        tx_ready,
   output logic        corr_reset,
   output logic        we,
   output logic [31:0] cr,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
   localparam logic [31:0] RUN_LAST = TIMEOUT - 32'd1;
   localparam logic [5:0]  IDX_LAST = 6'd47;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_CFG,
      S_RUN,
      S_HDR,
      S_STAT,
      S_DATA
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    rcnt_q, rcnt_d;
   logic [31:0]   tcnt_q, tcnt_d;
   logic [5:0]    idx_q, idx_d;
   logic [31:0]   cr_q, cr_d;
   logic [383:0]  snap_q, snap_d;
   logic [2:0]    stat_q, stat_d;
   logic          terr_q, terr_d;

   logic          st_done;
   logic          st_fail;
   logic          st_tmo;
   logic [8:0]    bit_hi;
   logic          unused_sr;

   assign st_done   = sr_in[0];
   assign st_fail   = sr_in[1];
   assign st_tmo    = (tcnt_q == RUN_LAST);
   assign unused_sr = ^sr_in[31:2];

   // Snapshot is packed with sum_x_2 in the top word, so byte index i
   // maps to a descending bit window starting at the MSB.
   assign bit_hi = 9'd383 - {idx_q, 3'b000};

   assign busy        = (state_q != S_IDLE);
   assign timeout_err = terr_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= S_IDLE;
         rcnt_q  <= '0;
         tcnt_q  <= '0;
         idx_q   <= '0;
         cr_q    <= '0;
         snap_q  <= '0;
         stat_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         tcnt_q  <= tcnt_d;
         idx_q   <= idx_d;
         cr_q    <= cr_d;
         snap_q  <= snap_d;
         stat_q  <= stat_d;
         terr_q  <= terr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rcnt_d     = rcnt_q;
      tcnt_d     = tcnt_q;
      idx_d      = idx_q;
      cr_d       = cr_q;
      snap_d     = snap_q;
      stat_d     = stat_q;
      terr_d     = terr_q;
      corr_reset = 1'b0;
      we         = 1'b0;
      cr         = cr_q;
      tx_valid   = 1'b0;
      tx_byte    = 8'h00;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RST;
               rcnt_d  = '0;
               terr_d  = 1'b0;
            end
         end

         S_RST: begin
            corr_reset = 1'b1;
            if (rcnt_q == RST_LAST) begin
               rcnt_d  = '0;
               state_d = S_CFG;
            end else begin
               rcnt_d = rcnt_q + 8'd1;
            end
         end

         S_CFG: begin
            // cr follows cr_value on the strobe cycle, then holds the latch.
            we      = 1'b1;
            cr      = cr_value;
            cr_d    = cr_value;
            tcnt_d  = '0;
            state_d = S_RUN;
         end

         S_RUN: begin
            tcnt_d = tcnt_q + 32'd1;
            if (st_done || st_fail || st_tmo) begin
               snap_d  = {sum_x_2, sum_y_2, sum_xy,
                          sum_xy90, sum_y90_2, sum_y_y90};
               stat_d  = {st_tmo, st_fail, st_done};
               state_d = S_HDR;
               if (st_tmo) begin
                  terr_d = 1'b1;
               end
            end
         end

         S_HDR: begin
            tx_valid = 1'b1;
            tx_byte  = 8'hA5;
            if (tx_ready) begin
               state_d = S_STAT;
            end
         end

         S_STAT: begin
            tx_valid = 1'b1;
            tx_byte  = {5'b00000, stat_q};
            if (tx_ready) begin
               // Any error bit truncates the frame to header + status.
               if (stat_q[2:1] != 2'b00) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            tx_valid = 1'b1;
            tx_byte  = snap_q[bit_hi -: 8];
            if (tx_ready) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 6'd1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/corr_acq_sequencer.md
CORR_ACQ_SEQUENCER -- requirements
Module: corr_acq_sequencer

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: number of cycles corr_reset is held high per acquisition (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 32'd10000000: sys_clk cycles allowed in RUN before abort.
REQ-003 SHALL have port sys_clk, input, 1: the only clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: single-cycle acquisition request.
REQ-006 SHALL have port cr_value, input, 32: control word written to the correlator.
REQ-007 SHALL have port sr_in, input, 32: correlator status; bit0 = done, bit1 = failure.
REQ-008 SHALL have ports sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2 and sum_y_y90, each input, 64: correlator accumulators.
REQ-009 SHALL have port tx_ready, input, 1: the UART transmitter accepts a byte.
REQ-010 SHALL have port corr_reset, output, 1: correlator reset.
REQ-011 SHALL have port we, output, 1: control-register write strobe.
REQ-012 SHALL have port cr, output, 32: control-register data.
REQ-013 SHALL have port tx_byte, output, 8: byte to transmit.
REQ-014 SHALL have port tx_valid, output, 1: tx_byte is valid.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port timeout_err, output, 1: sticky flag set by a RUN timeout and cleared by the next accepted start.

Function
REQ-017 SHALL implement the FSM states IDLE, RST, CFG, RUN, HDR, STAT, DATA.
REQ-018 In IDLE, start=1 SHALL move the FSM to RST on the next cycle and clear timeout_err.
REQ-019 start SHALL be ignored in every state other than IDLE.
REQ-020 In RST, corr_reset SHALL be 1 for exactly RST_CYCLES consecutive cycles, after which the FSM moves to CFG.
REQ-021 In CFG, we SHALL be 1 for exactly one cycle, with cr = cr_value sampled on that cycle and held until the next CFG; the FSM then moves to RUN.
REQ-022 In RUN, a 32-bit cycle counter SHALL start at 0 and increment each cycle.
REQ-023 In RUN, the first cycle in which any of the following is true SHALL end RUN: sr_in[0]=1, sr_in[1]=1, or counter = TIMEOUT-1.
REQ-024 If done, failure and timeout coincide in the same cycle, all applicable status bits SHALL be recorded.
REQ-025 A RUN timeout SHALL set timeout_err.
REQ-026 On the RUN exit cycle, the six sums SHALL be snapshotted into internal registers (384 bits) and status byte S = {5'b0, timeout, sr_in[1], sr_in[0]} latched; the FSM then moves to HDR.
REQ-027 HDR SHALL present tx_byte=8'hA5; STAT SHALL present S.
REQ-028 DATA SHALL send 48 bytes in the order sum_x_2, sum_y_2, sum_xy, sum_xy90, sum_y90_2, sum_y_y90, each MSB byte first, using a 6-bit byte index 0..47.
REQ-029 Each byte SHALL transfer on a cycle with tx_valid=1 and tx_ready=1.
REQ-030 tx_valid SHALL stay 1 and tx_byte SHALL stay stable until the transfer.
REQ-031 The next byte SHALL be presented on the cycle after a transfer, giving a maximum rate of one byte per cycle.
REQ-032 After STAT transfers: if S[2:1] != 0 the FSM SHALL go to IDLE and DATA SHALL be skipped (2-byte frame); otherwise it SHALL go to DATA.
REQ-033 After byte 47 transfers, the FSM SHALL go to IDLE and tx_valid SHALL be 0 on the next cycle.
REQ-034 tx_valid SHALL be 0 outside HDR, STAT and DATA.
REQ-035 Changes to the sum inputs after the snapshot SHALL NOT affect transmitted data.
REQ-036 sr_in changes outside RUN SHALL be ignored.

Reset
REQ-037 On a sys_clk edge with sys_rst=1, the following SHALL hold on the next cycle: state=IDLE; corr_reset=0, we=0, cr=0, tx_valid=0, tx_byte=0, busy=0, timeout_err=0; all counters and snapshots = 0.
REQ-038 A reset in any state, including mid-byte with tx_valid=1, SHALL abort the frame with no further bytes.
REQ-039 A start asserted in the same cycle as sys_rst SHALL be ignored.

Verification
REQ-040 Nominal: cr_value=32'h0000_0103, start pulse, done asserted 100 cycles into RUN, tx_ready=1, sum_x_2=64'h0102030405060708 -> corr_reset high 16 cycles, one we pulse with cr=32'h103, bytes A5, 01, 01, 02 .. 08, then the rest, 50 bytes total, busy low after the last byte.
REQ-041 Failure: sr_in[1]=1 in RUN -> exactly 2 bytes, A5 then 02; timeout_err=0.
REQ-042 Timeout: TIMEOUT=1000, no done -> RUN lasts 1000 cycles; bytes A5 then 04; timeout_err=1 until the next start.
REQ-043 Backpressure: tx_ready toggled randomly during DATA and the sums changed after the snapshot -> tx_byte stable while stalled, no byte lost or duplicated, snapshot values sent.
REQ-044 Reset mid-operation: sys_rst at DATA byte 20 -> next cycle tx_valid=0, busy=0, all outputs at reset values; a following start yields a complete new frame.
REQ-045 Start while busy: a start pulse during RUN and another during DATA -> ignored, exactly one frame sent.
